// File: rtl/rs_issue_arb.sv
// rs_issue_arb -- multi-grant issue arbiter for a reservation station.
// Each cycle up to REQS ready entries are picked from req. Grant slice j
// holds the (j+1)-th requesting entry found by scanning upward from the
// priority pointer and wrapping around. All grant outputs are registered.
//
// Configuration macro: RS_ISSUE_ARB_ROTATE_EN
//   defined   - ptr advances past the last granted entry (round-robin).
//   undefined - ptr is tied to 0, giving a fixed lowest-index-first scan.
module rs_issue_arb #(
    parameter int WIDTH = 16,
    parameter int REQS  = 2,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(REQS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    stall,
    input  logic [WIDTH-1:0]        req,
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic [REQS-1:0]         gnt_valid,
    output logic [REQS*IDX_W-1:0]   gnt_idx,
    output logic [CNT_W-1:0]        num_gnt,
    output logic [IDX_W-1:0]        ptr
);

    // Entry count widened by one bit so the modulo-WIDTH wrap compare is exact
    // even when WIDTH is not a power of two.
    localparam logic [IDX_W:0] WIDTH_EXT = (IDX_W + 1)'(WIDTH);

    logic [WIDTH-1:0]        rot_req;   // req rotated so bit 0 is the entry at ptr
    logic [IDX_W:0]          pos;
    logic [WIDTH-1:0]        mask;
    logic                    found;
    logic [IDX_W-1:0]        off;
    logic [IDX_W:0]          sum;
    logic [WIDTH*REQS-1:0]   gnt_bus_n;
    logic [REQS-1:0]         gnt_valid_n;
    logic [REQS*IDX_W-1:0]   gnt_idx_n;
    logic [CNT_W-1:0]        num_n;

`ifdef RS_ISSUE_ARB_ROTATE_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0]        last_idx;
    logic [IDX_W-1:0]        ptr_next;
`endif

    // Rotate the request vector so that the scan always starts at bit 0.
    always_comb begin
        // NOTE: every variable written here gets a value on every path first;
        // otherwise synthesis infers a latch to hold the old value.
        rot_req = '0;
        pos     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= WIDTH_EXT) begin
                pos = pos - WIDTH_EXT;
            end
            rot_req[i] = req[pos[IDX_W-1:0]];
        end
    end

    // Peel off the lowest remaining request once per slice and map the
    // rotated offset back to an absolute entry index.
    always_comb begin
        mask        = rot_req;
        found       = 1'b0;
        off         = '0;
        sum         = '0;
        gnt_bus_n   = '0;
        gnt_valid_n = '0;
        gnt_idx_n   = '0;
        num_n       = '0;
`ifdef RS_ISSUE_ARB_ROTATE_EN
        last_idx    = ptr;
`endif
        for (int j = 0; j < REQS; j++) begin
            found = 1'b0;
            off   = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (!found && mask[i]) begin
                    found = 1'b1;
                    off   = IDX_W'(i);
                end
            end
            if (found) begin
                mask[off] = 1'b0;
                sum = {1'b0, ptr} + {1'b0, off};
                if (sum >= WIDTH_EXT) begin
                    sum = sum - WIDTH_EXT;
                end
                gnt_bus_n[j*WIDTH +: WIDTH]   = WIDTH'(1) << sum[IDX_W-1:0];
                gnt_valid_n[j]                = 1'b1;
                gnt_idx_n[j*IDX_W +: IDX_W]   = sum[IDX_W-1:0];
                num_n                         = num_n + CNT_W'(1);
`ifdef RS_ISSUE_ARB_ROTATE_EN
                last_idx                      = sum[IDX_W-1:0];
`endif
            end
        end
    end

`ifdef RS_ISSUE_ARB_ROTATE_EN
    // Next pointer is one past the last granted entry, wrapping to 0.
    always_comb begin
        ptr_next = (last_idx == LAST_IDX) ? '0 : last_idx + IDX_W'(1);
    end

    // Priority pointer: advances only on a real grant; stall freezes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (!stall && en && (num_n != '0)) begin
            ptr <= ptr_next;
        end
    end
`else
    // Fixed priority: the scan always starts at entry 0.
    assign ptr = '0;
`endif

    // Grant output registers: stall holds, en=0 clears, otherwise load.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            gnt_bus   <= '0;
            gnt_valid <= '0;
            gnt_idx   <= '0;
            num_gnt   <= '0;
        end else if (!stall) begin
            if (en) begin
                gnt_bus   <= gnt_bus_n;
                gnt_valid <= gnt_valid_n;
                gnt_idx   <= gnt_idx_n;
                num_gnt   <= num_n;
            end else begin
                gnt_bus   <= '0;
                gnt_valid <= '0;
                gnt_idx   <= '0;
                num_gnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_arb.sv
// tb_rs_issue_arb -- directed bench for rs_issue_arb with WIDTH=8, REQS=2.
// Expected values are hand-computed for both settings of
// RS_ISSUE_ARB_ROTATE_EN; ROT selects the set matching the build.
module tb_rs_issue_arb;

    localparam int WIDTH = 8;
    localparam int REQS  = 2;

`ifdef RS_ISSUE_ARB_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        stall;
    logic [7:0]  req;
    logic [15:0] gnt_bus;
    logic [1:0]  gnt_valid;
    logic [5:0]  gnt_idx;
    logic [1:0]  num_gnt;
    logic [2:0]  ptr;

    int vectors     = 0;
    int miscompares = 0;

    rs_issue_arb #(.WIDTH(WIDTH), .REQS(REQS)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .stall     (stall),
        .req       (req),
        .gnt_bus   (gnt_bus),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .num_gnt   (num_gnt),
        .ptr       (ptr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_bus,
                             input logic [1:0] e_valid, input logic [5:0] e_idx,
                             input logic [1:0] e_num, input logic [2:0] e_ptr);
        check($sformatf("%s.gnt_bus", tag),   32'(gnt_bus),   32'(e_bus));
        check($sformatf("%s.gnt_valid", tag), 32'(gnt_valid), 32'(e_valid));
        check($sformatf("%s.gnt_idx", tag),   32'(gnt_idx),   32'(e_idx));
        check($sformatf("%s.num_gnt", tag),   32'(num_gnt),   32'(e_num));
        check($sformatf("%s.ptr", tag),       32'(ptr),       32'(e_ptr));
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; stall = 1'b0; req = 8'h00;
        step();
        check_out("reset", 16'h0000, 2'b00, 6'h00, 2'd0, 3'd0);

        // Two grants from ptr 0: entries 1 and 2.
        reset = 1'b0; en = 1'b1; req = 8'b0001_0110;
        step();
        check_out("two_grant", 16'h0402, 2'b11, 6'h11, 2'd2, ROT ? 3'd3 : 3'd0);

        // Entries 0 and 7: wrap-around when rotating from ptr 3.
        req = 8'b1000_0001;
        step();
        check_out("wrap",
                  ROT ? 16'h0180 : 16'h8001, 2'b11,
                  ROT ? 6'h07 : 6'h38, 2'd2, ROT ? 3'd1 : 3'd0);

        // Reset back to ptr 0, then a single request.
        reset = 1'b1;
        step();
        check_out("reset2", 16'h0000, 2'b00, 6'h00, 2'd0, 3'd0);
        reset = 1'b0; req = 8'b0010_0000;
        step();
        check_out("single", 16'h0020, 2'b01, 6'h05, 2'd1, ROT ? 3'd6 : 3'd0);

        // Stall for three cycles while req changes: everything holds.
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = (c == 1) ? 8'hFF : 8'h3C;
            step();
            check_out($sformatf("stall%0d", c), 16'h0020, 2'b01, 6'h05, 2'd1,
                      ROT ? 3'd6 : 3'd0);
        end

        // en=0 without stall clears grants, ptr holds.
        stall = 1'b0; en = 1'b0; req = 8'hFF;
        step();
        check_out("disable", 16'h0000, 2'b00, 6'h00, 2'd0, ROT ? 3'd6 : 3'd0);

        // No requests: grants zero, ptr holds.
        en = 1'b1; req = 8'h00;
        step();
        check_out("no_req", 16'h0000, 2'b00, 6'h00, 2'd0, ROT ? 3'd6 : 3'd0);

        // Entries 3 and 6 scanned from ptr 6 (rotating) or 0 (fixed).
        req = 8'b0100_1000;
        step();
        check_out("from_ptr6",
                  ROT ? 16'h0840 : 16'h4008, 2'b11,
                  ROT ? 6'h1E : 6'h33, 2'd2, ROT ? 3'd4 : 3'd0);

        // Reset overrides stall and a full request vector.
        reset = 1'b1; stall = 1'b1; req = 8'hFF;
        step();
        check_out("reset_stall", 16'h0000, 2'b00, 6'h00, 2'd0, 3'd0);

        // First grant after reset comes from ptr 0; second depends on mode.
        reset = 1'b0; stall = 1'b0;
        step();
        check_out("ff_cyc1", 16'h0201, 2'b11, 6'h08, 2'd2, ROT ? 3'd2 : 3'd0);
        step();
        check_out("ff_cyc2",
                  ROT ? 16'h0804 : 16'h0201, 2'b11,
                  ROT ? 6'h1A : 6'h08, 2'd2, ROT ? 3'd4 : 3'd0);

        // Stall together with en=0: stall wins, outputs hold.
        stall = 1'b1; en = 1'b0;
        step();
        check_out("stall_en0",
                  ROT ? 16'h0804 : 16'h0201, 2'b11,
                  ROT ? 6'h1A : 6'h08, 2'd2, ROT ? 3'd4 : 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
